// File: rtl/id_hazard_stage.sv
// ID-to-EX operand resolution: forwarding, long-latency scoreboard,
// RAW/WAW stall generation and the ID/EX pipeline register.
module id_hazard_stage #(
  parameter  int XLEN    = 32,
  parameter  int NUM_FWD = 2,
  parameter  int NREG    = 32,
  localparam int RW      = $clog2(NREG)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [RW-1:0]           in_rs1_s_i,
  input  logic [RW-1:0]           in_rs2_s_i,
  input  logic [RW-1:0]           in_rd_s_i,
  input  logic                    in_uses_rs1_i,
  input  logic                    in_uses_rs2_i,
  input  logic                    in_rd_we_i,
  input  logic                    in_long_lat_i,
  input  logic [XLEN-1:0]         in_rs1_v_i,
  input  logic [XLEN-1:0]         in_rs2_v_i,
  input  logic [NUM_FWD-1:0]      fwd_valid_i,
  input  logic [NUM_FWD*RW-1:0]   fwd_rd_s_i,
  input  logic [NUM_FWD*XLEN-1:0] fwd_rd_v_i,
  input  logic [NUM_FWD-1:0]      fwd_data_ok_i,
  input  logic                    done_valid_i,
  input  logic [RW-1:0]           done_rd_s_i,
  input  logic [XLEN-1:0]         done_rd_v_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [XLEN-1:0]         out_rs1_v_o,
  output logic [XLEN-1:0]         out_rs2_v_o,
  output logic [RW-1:0]           out_rd_s_o,
  output logic                    out_rd_we_o,
  output logic                    out_long_lat_o,
  output logic [1:0]              stall_o,
  output logic [NREG-1:0]         pending_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [XLEN:0]   res1;
  logic [XLEN:0]   res2;
  logic            raw;
  logic            waw;
  logic            live;
  logic            adv;
  logic            accept;
  logic            done_rd;

  // Returns {raw_hazard, value}; lower indices are walked last so they win.
  function automatic logic [XLEN:0] resolve(
    input logic [RW-1:0]   rs,
    input logic [XLEN-1:0] rf
  );
    logic            hit;
    logic            ok;
    logic            hz;
    logic [XLEN-1:0] v;
    hit = 1'b0;
    ok  = 1'b1;
    hz  = 1'b0;
    v   = rf;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid_i[i] && fwd_rd_s_i[i*RW +: RW] == rs) begin
        hit = 1'b1;
        ok  = fwd_data_ok_i[i];
        v   = fwd_rd_v_i[i*XLEN +: XLEN];
      end
    end
    if (hit) begin
      hz = !ok;
    end else if (done_valid_i && done_rd_s_i == rs) begin
      v = done_rd_v_i;
    end else if (pending_q[rs]) begin
      hz = 1'b1;
    end
    if (rs == '0) begin
      v  = '0;
      hz = 1'b0;
    end
    return {hz, v};
  endfunction

  assign res1 = resolve(in_rs1_s_i, in_rs1_v_i);
  assign res2 = resolve(in_rs2_s_i, in_rs2_v_i);

  assign live    = in_valid_i && !flush_i;
  assign done_rd = done_valid_i && done_rd_s_i == in_rd_s_i;

  assign raw = live &&
               ((in_uses_rs1_i && res1[XLEN]) ||
                (in_uses_rs2_i && res2[XLEN]));

  assign waw = live && in_rd_we_i && in_long_lat_i &&
               in_rd_s_i != '0 && pending_q[in_rd_s_i] && !done_rd;

  assign stall_o    = {waw, raw};
  assign adv        = !out_valid_o || out_ready_i;
  assign in_ready_o = flush_i || (adv && stall_o == 2'b00);
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign pending_o  = pending_q;

  // Set is applied after clear so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (done_valid_i) begin
      pending_d[done_rd_s_i] = 1'b0;
    end
    if (accept && in_rd_we_i && in_long_lat_i && in_rd_s_i != '0) begin
      pending_d[in_rd_s_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o    <= 1'b0;
      out_rs1_v_o    <= '0;
      out_rs2_v_o    <= '0;
      out_rd_s_o     <= '0;
      out_rd_we_o    <= 1'b0;
      out_long_lat_o <= 1'b0;
    end else if (accept) begin
      out_valid_o    <= 1'b1;
      out_rs1_v_o    <= res1[XLEN-1:0];
      out_rs2_v_o    <= res2[XLEN-1:0];
      out_rd_s_o     <= in_rd_s_i;
      out_rd_we_o    <= in_rd_we_i;
      out_long_lat_o <= in_long_lat_i;
    end else if (adv) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_hazard_stage.sv
// Directed bench for id_hazard_stage: expected ID/EX contents are queued
// when an accept is expected and compared one cycle later.
module tb_id_hazard_stage;

  localparam int XLEN = 32;
  localparam int NF   = 2;
  localparam int NREG = 32;
  localparam int RW   = 5;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [RW-1:0]   rd;
    logic            we;
    logic            ll;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [RW-1:0]     rs1, rs2, rd;
  logic              u1, u2, we, ll;
  logic [XLEN-1:0]   v1, v2;
  logic [NF-1:0]     fv;
  logic [NF*RW-1:0]  frd;
  logic [NF*XLEN-1:0] fval;
  logic [NF-1:0]     fok;
  logic              dv;
  logic [RW-1:0]     drd;
  logic [XLEN-1:0]   dval;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   o1, o2;
  logic [RW-1:0]     ord;
  logic              owe, oll;
  logic [1:0]        stall;
  logic [NREG-1:0]   pend;

  int   compared = 0;
  int   mismatched = 0;
  exp_t q[$];

  id_hazard_stage #(.XLEN(XLEN), .NUM_FWD(NF), .NREG(NREG)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs1_s_i(rs1), .in_rs2_s_i(rs2), .in_rd_s_i(rd),
    .in_uses_rs1_i(u1), .in_uses_rs2_i(u2),
    .in_rd_we_i(we), .in_long_lat_i(ll),
    .in_rs1_v_i(v1), .in_rs2_v_i(v2),
    .fwd_valid_i(fv), .fwd_rd_s_i(frd), .fwd_rd_v_i(fval),
    .fwd_data_ok_i(fok),
    .done_valid_i(dv), .done_rd_s_i(drd), .done_rd_v_i(dval),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rs1_v_o(o1), .out_rs2_v_o(o2), .out_rd_s_o(ord),
    .out_rd_we_o(owe), .out_long_lat_o(oll),
    .stall_o(stall), .pending_o(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 0; in_valid = 0;
    rs1 = 0; rs2 = 0; rd = 0;
    u1 = 0; u2 = 0; we = 0; ll = 0;
    v1 = 0; v2 = 0;
    fv = 0; frd = 0; fval = 0; fok = 0;
    dv = 0; drd = 0; dval = 0;
  endtask

  task automatic instr(input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                       input logic [RW-1:0] d, input logic a1,
                       input logic a2, input logic w, input logic l,
                       input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
    in_valid = 1;
    rs1 = s1; rs2 = s2; rd = d;
    u1 = a1; u2 = a2; we = w; ll = l;
    v1 = r1; v2 = r2;
  endtask

  task automatic fwd(input int i, input logic val, input logic [RW-1:0] d,
                     input logic [XLEN-1:0] v, input logic ok);
    fv[i] = val;
    frd[i*RW +: RW] = d;
    fval[i*XLEN +: XLEN] = v;
    fok[i] = ok;
  endtask

  task automatic expect_acc(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [RW-1:0] d, input logic w,
                            input logic l);
    exp_t e;
    e.a = a; e.b = b; e.rd = d; e.we = w; e.ll = l;
    q.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      mismatched++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_rs1"}, 64'(o1), 64'(e.a));
      chk({tag, "_rs2"}, 64'(o2), 64'(e.b));
      chk({tag, "_rd"}, 64'({owe, oll, ord}), 64'({e.we, e.ll, e.rd}));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_edge();
    @(negedge clk);
    idle();
  endtask

  initial begin
    idle();
    out_ready = 1;
    rst_n = 0;
    #2;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_pend", 64'(pend), 64'd0);
    chk("reset_data", 64'({o1, o2}), 64'd0);
    drv_edge();
    rst_n = 1;

    // A: ALU write x5
    drv_edge();
    instr(1, 0, 5, 1, 0, 1, 0, 32'h11, 0);
    #1;
    chk("a_ready", 64'(in_ready), 64'd1);
    expect_acc(32'h11, 0, 5, 1, 0);
    tick();
    pop_chk("a_out");

    // B: reads x5, fwd0 beats fwd1
    drv_edge();
    instr(5, 0, 6, 1, 0, 1, 0, 0, 0);
    fwd(0, 1, 5, 32'h1234, 1);
    fwd(1, 1, 5, 32'h9999, 1);
    #1;
    chk("b_stall", 64'(stall), 64'd0);
    chk("b_ready", 64'(in_ready), 64'd1);
    expect_acc(32'h1234, 0, 6, 1, 0);
    tick();
    pop_chk("b_out");

    // load-use on x7
    drv_edge();
    instr(7, 0, 8, 1, 0, 1, 0, 0, 0);
    fwd(0, 1, 7, 32'h0, 0);
    #1;
    chk("lu_stall", 64'(stall), 64'b01);
    chk("lu_ready", 64'(in_ready), 64'd0);
    tick();
    chk("lu_bubble", 64'(out_valid), 64'd0);
    drv_edge();
    instr(7, 0, 8, 1, 0, 1, 0, 0, 0);
    fwd(1, 1, 7, 32'hCAFE, 1);
    #1;
    chk("lu2_stall", 64'(stall), 64'd0);
    expect_acc(32'hCAFE, 0, 8, 1, 0);
    tick();
    pop_chk("lu_out");

    // long-latency writer to x9
    drv_edge();
    instr(0, 0, 9, 0, 0, 1, 1, 0, 0);
    expect_acc(0, 0, 9, 1, 1);
    tick();
    pop_chk("ll_out");
    chk("ll_pend9", 64'(pend[9]), 64'd1);

    // reader of x9 stalls 3 cycles
    for (int c = 0; c < 3; c++) begin
      drv_edge();
      instr(0, 9, 10, 0, 1, 1, 0, 0, 32'h5);
      #1;
      chk("sb_stall", 64'({in_ready, stall}), 64'b001);
      tick();
    end
    chk("sb_bubble", 64'(out_valid), 64'd0);
    drv_edge();
    instr(0, 9, 10, 0, 1, 1, 0, 0, 32'h5);
    dv = 1; drd = 9; dval = 32'hBEEF;
    #1;
    chk("sb_done_stall", 64'({in_ready, stall}), 64'b100);
    expect_acc(0, 32'hBEEF, 10, 1, 0);
    tick();
    pop_chk("sb_out");
    chk("sb_pend9", 64'(pend[9]), 64'd0);

    // WAW on x9
    drv_edge();
    instr(0, 0, 9, 0, 0, 1, 1, 0, 0);
    expect_acc(0, 0, 9, 1, 1);
    tick();
    pop_chk("w1_out");
    drv_edge();
    instr(0, 0, 9, 0, 0, 1, 1, 0, 0);
    #1;
    chk("waw_stall", 64'({in_ready, stall}), 64'b010);
    tick();
    drv_edge();
    instr(0, 0, 9, 0, 0, 1, 1, 0, 0);
    dv = 1; drd = 9; dval = 32'h1;
    #1;
    chk("waw_done", 64'({in_ready, stall}), 64'b100);
    expect_acc(0, 0, 9, 1, 1);
    tick();
    pop_chk("w2_out");
    chk("waw_pend9", 64'(pend[9]), 64'd1);

    // backpressure holds the output
    for (int c = 0; c < 2; c++) begin
      drv_edge();
      out_ready = 0;
      instr(1, 0, 3, 1, 0, 1, 0, 32'h77, 0);
      #1;
      chk("bp_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_hold", 64'({out_valid, oll, ord}), 64'({1'b1, 1'b1, 5'd9}));
    end

    // flush kills input; output drains to a bubble
    drv_edge();
    out_ready = 1;
    instr(0, 0, 12, 0, 0, 1, 1, 0, 0);
    flush = 1;
    #1;
    chk("fl_ready", 64'({in_ready, stall}), 64'b100);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_pend12", 64'(pend[12]), 64'd0);

    // x0 reader with fwd0 writing x0
    drv_edge();
    instr(0, 0, 4, 1, 0, 1, 0, 32'h77, 0);
    fwd(0, 1, 0, 32'h5555, 0);
    #1;
    chk("x0_stall", 64'({in_ready, stall}), 64'b100);
    expect_acc(0, 0, 4, 1, 0);
    tick();
    pop_chk("x0_out");

    // reset mid-stall, no clock edge
    drv_edge();
    out_ready = 0;
    instr(9, 0, 11, 1, 0, 1, 0, 0, 0);
    #1;
    chk("rst_pre_stall", 64'(stall), 64'b01);
    #1;
    rst_n = 0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pend", 64'(pend), 64'd0);
    q.delete();
    idle();
    #10;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
